// File: rtl/spi_raspberry_master.sv
// SPI mode-0 master, LSB first, for the Raspberry SPI link.
// Frame: CS lead, BITS clock periods, CS trail, then an inter-frame gap.
module spi_raspberry_master #(
  parameter int BITS     = 512,
  parameter int CLK_DIV  = 20,
  parameter int CS_LEAD  = 20,
  parameter int CS_TRAIL = 20,
  parameter int CS_GAP   = 40
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [BITS-1:0] data_tx,
  input  logic            spi_miso,
  output logic            spi_cs,
  output logic            spi_clk,
  output logic            spi_mosi,
  output logic [BITS-1:0] data_rx,
  output logic            busy,
  output logic            done
);

  localparam int M1   = (CLK_DIV > CS_LEAD) ? CLK_DIV : CS_LEAD;
  localparam int M2   = (CS_TRAIL > CS_GAP) ? CS_TRAIL : CS_GAP;
  localparam int MAXP = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int BW   = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [CW-1:0] LEAD_END  = CW'(CS_LEAD - 1);
  localparam logic [CW-1:0] DIV_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] TRAIL_END = CW'(CS_TRAIL - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_LOW,
    S_HIGH,
    S_TRAIL,
    S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [BITS-1:0] tx_q, tx_d;
  logic [BITS-1:0] rx_q, rx_d;
  logic [BITS-1:0] rxo_q, rxo_d;
  logic            cs_q, cs_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            miso_s1_q, miso_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rxo_q     <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rxo_q     <= rxo_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxo_d   = rxo_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_d    = data_tx;
          rx_d    = '0;
          bit_d   = '0;
          cnt_d   = '0;
          cs_d    = 1'b0;
          mosi_d  = data_tx[0];
          busy_d  = 1'b1;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (cnt_q == LEAD_END) begin
          cnt_d   = '0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_q == DIV_END) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == DIV_END) begin
          cnt_d = '0;
          sck_d = 1'b0;
          // LSB-first: the newest sample enters at the top
          rx_d  = {miso_s2_q, rx_q[BITS-1:1]};
          if (bit_q != LAST_BIT) begin
            tx_d    = {1'b0, tx_q[BITS-1:1]};
            mosi_d  = tx_q[1];
            bit_d   = bit_q + 1'b1;
            state_d = S_LOW;
          end else begin
            mosi_d  = 1'b0;
            state_d = S_TRAIL;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TRAIL: begin
        if (cnt_q == TRAIL_END) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          rxo_d   = rx_q;
          done_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign spi_cs   = cs_q;
  assign spi_clk  = sck_q;
  assign spi_mosi = mosi_q;
  assign data_rx  = rxo_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_raspberry_master.sv
// Directed bench for spi_raspberry_master: reset, loopback, bit order,
// start handling, back-to-back gap and mid-frame reset.
module tb_spi_raspberry_master;

  localparam int BITS = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [BITS-1:0] data_tx = '0;
  logic            miso_v = 1'b0;
  logic            loop_en = 1'b0;
  logic            spi_miso;
  logic            spi_cs, spi_clk, spi_mosi, busy, done;
  logic [BITS-1:0] data_rx;

  int vectors = 0;
  int miscompares = 0;

  int   rise_cnt = 0;
  int   cslow_cnt = 0;
  int   done_cnt = 0;
  logic sck_prev = 1'b0;
  logic mosi_hist [0:1023];

  assign spi_miso = loop_en ? spi_mosi : miso_v;

  spi_raspberry_master #(
    .BITS(BITS),
    .CLK_DIV(4),
    .CS_LEAD(2),
    .CS_TRAIL(2),
    .CS_GAP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .data_tx(data_tx),
    .spi_miso(spi_miso),
    .spi_cs(spi_cs),
    .spi_clk(spi_clk),
    .spi_mosi(spi_mosi),
    .data_rx(data_rx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Bus monitor sampled mid-cycle
  always @(negedge clk) begin
    sck_prev <= spi_clk;
    if (spi_clk && !sck_prev) begin
      mosi_hist[rise_cnt % 1024] <= spi_mosi;
      rise_cnt <= rise_cnt + 1;
    end
    if (!spi_cs) cslow_cnt <= cslow_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rises(input int target, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (rise_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic launch(input logic [BITS-1:0] d);
    @(negedge clk);
    data_tx = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  initial begin
    int rb, cb, db, n;
    logic rest;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_cs", {31'd0, spi_cs}, 32'd1);
    chk("rst_sck", {31'd0, spi_clk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rx", {16'd0, data_rx}, 32'd0);

    // Loopback 0x1234
    loop_en = 1'b1;
    rb = rise_cnt;
    cb = cslow_cnt;
    db = done_cnt;
    @(negedge clk);
    data_tx = 16'h1234;
    start   = 1'b1;
    @(posedge clk);
    #1;
    chk("acc_cs", {31'd0, spi_cs}, 32'd0);
    chk("acc_busy", {31'd0, busy}, 32'd1);
    chk("acc_mosi", {31'd0, spi_mosi}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    wait_done("lb_done_seen");
    chk("lb_busy_at_done", {31'd0, busy}, 32'd1);
    chk("lb_cs_at_done", {31'd0, spi_cs}, 32'd1);
    chk("lb_rises", rise_cnt - rb, 32'd16);
    chk("lb_cs_low", cslow_cnt - cb, 32'd132);
    chk("lb_rx", {16'd0, data_rx}, 32'h1234);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
    chk("lb_gap_to_idle", n, 32'd4);
    chk("lb_done_pulses", done_cnt - db, 32'd1);

    // Bit order, MISO tied high
    loop_en = 1'b0;
    miso_v  = 1'b1;
    rb = rise_cnt;
    launch(16'h0005);
    wait_done("bo_done_seen");
    chk("bo_mosi0", {31'd0, mosi_hist[(rb + 0) % 1024]}, 32'd1);
    chk("bo_mosi1", {31'd0, mosi_hist[(rb + 1) % 1024]}, 32'd0);
    chk("bo_mosi2", {31'd0, mosi_hist[(rb + 2) % 1024]}, 32'd1);
    chk("bo_mosi3", {31'd0, mosi_hist[(rb + 3) % 1024]}, 32'd0);
    rest = 1'b0;
    for (int i = 4; i < 16; i++) rest = rest | mosi_hist[(rb + i) % 1024];
    chk("bo_mosi_rest", {31'd0, rest}, 32'd0);
    chk("bo_rx", {16'd0, data_rx}, 32'hFFFF);
    wait_idle("bo_idle");

    // Start ignored mid-frame, then held start for back-to-back
    loop_en = 1'b1;
    rb = rise_cnt;
    launch(16'hA5C3);
    wait_rises(rb + 8, "sh_bit7_reached");
    data_tx = 16'hFFFF;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (3) @(negedge clk);
    data_tx = 16'h0F0F;
    start   = 1'b1;
    wait_done("sh_done_seen");
    chk("sh_rx_first", {16'd0, data_rx}, 32'hA5C3);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!spi_cs) break;
      n++;
    end
    chk("sh_cs_high", n, 32'd5);
    start = 1'b0;
    wait_done("sh2_done_seen");
    chk("sh_rx_second", {16'd0, data_rx}, 32'h0F0F);
    wait_idle("sh_idle");

    // Reset mid-frame at bit 7
    rb = rise_cnt;
    db = done_cnt;
    launch(16'h5555);
    wait_rises(rb + 8, "mr_bit7_reached");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_cs", {31'd0, spi_cs}, 32'd1);
    chk("mr_sck", {31'd0, spi_clk}, 32'd0);
    chk("mr_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_rx", {16'd0, data_rx}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("mr_no_done", done_cnt - db, 32'd0);
    chk("mr_rx_hold", {16'd0, data_rx}, 32'd0);
    rb = rise_cnt;
    launch(16'h3C3C);
    wait_done("mr2_done_seen");
    chk("mr2_rises", rise_cnt - rb, 32'd16);
    chk("mr2_rx", {16'd0, data_rx}, 32'h3C3C);
    wait_idle("mr2_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
